uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver for the board's 50 MHz domain. It recovers 8N1 frames (1 start, 8 data bits LSB-first, 1 stop, idle high) from the `rx` pin at 115200 baud. Each received byte is presented on a valid/ready holding register to downstream logic. It is the receive counterpart of the team's UART transmit path and uses the same bit period and framing.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 434 ≈ 115207 baud); must be ≥ 8.
- `HALF_BIT`, default `CLKS_PER_BIT/2` (217): cycles from start-edge detection to the start-bit sample.

- `clk_50M`  in  1  50 MHz system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; one clock, no other clock domains.
- `rx`  in  1  serial input, asynchronous to `clk_50M`, idle high.
- `rx_data`  out  8  last accepted byte; stable while `rx_valid`=1.
- `rx_valid`  out  1  byte available; held until consumed.
- `rx_ready`  in  1  consumer accept; a transfer occurs on a cycle with `rx_valid`&`rx_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low, byte discarded.
- `overrun`  out  1  sticky: a good byte completed while `rx_valid`=1; cleared only by reset.
- `busy`  out  1  FSM not in IDLE.

## Operation
- Synchronizer: `rx` passes through 2 flops to give `rx_s`; `rx_s_d` is a further delay flop. All three reset to 1.
- Start detection: in IDLE, a falling edge (`rx_s_d`=1, `rx_s`=0) moves the FSM to START with the bit counter at 0. A line held low (break) does not retrigger, because only a falling edge starts a frame.
- States are IDLE, START, DATA, STOP. The counter increments every cycle outside IDLE and clears on every sample.
  - START: sample `rx_s` when counter = `HALF_BIT`-1. If the sample is 1, the start was a glitch: go to IDLE and raise no flag. If 0, go to DATA with bit index 0.
  - DATA: sample when counter = `CLKS_PER_BIT`-1. The sampled bit shifts into the MSB of the shift register (right shift), so that after 8 samples bit 0 is the first bit received. After the 8th sample go to STOP.
  - STOP: sample when counter = `CLKS_PER_BIT`-1, then go to IDLE.
    - Sample 1 and `rx_valid`=0: load `rx_data` from the shift register and set `rx_valid`.
    - Sample 1 and `rx_valid`=1: keep the old `rx_data`, drop the new byte, set `overrun`.
    - Sample 0: pulse `frame_err` for one cycle, drop the byte, leave `rx_data`/`rx_valid` unchanged.
- Handshake: `rx_valid` clears on the cycle after `rx_valid`&`rx_ready`.
  - If a new good stop bit is sampled on the same cycle as the accept, the new byte loads and `rx_valid` stays 1. This is not an overrun.
  - `rx_ready` has no effect while `rx_valid`=0.
- Reset, including mid-frame: FSM goes to IDLE, counter and bit index to 0, shift register to 0x00.
  - Outputs after reset: `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0.
  - A partially received frame is discarded. Reception resumes at the next falling edge after reset is released.

## Timing
- Pin to edge detect: `rx` falls at cycle P; `rx_s`=0 at P+2. The edge is detected at P+2, and START is entered with counter 0 at P+3.
- Start sample at P+3+`HALF_BIT`-1. Data bit k (k = 0..7) sampled `HALF_BIT` + (k+1)·`CLKS_PER_BIT` − 1 cycles after P+3. Stop sampled `HALF_BIT` + 9·`CLKS_PER_BIT` − 1 cycles after P+3.
- `rx_valid` rises (or `frame_err` pulses) on the cycle after the stop sample. With defaults: P+3+217+3906 = P+4126.
- IDLE is re-entered the cycle after the stop sample. The next start edge is accepted from then on, so back-to-back frames need no extra idle time.
- `busy` is 1 from START entry up to and including the stop-sample cycle.
- Timing tolerance: sampling occurs at mid-bit ±1 cycle. Transmitter baud error up to ±2% must still decode correctly.

## Test plan
- Single frames: drive bytes 0x47, 0x42, 0x49, 0x31 at 434 cycles/bit with `rx_ready`=1. Expect `rx_data` to match each byte, one `rx_valid` pulse per byte at P+4126, `frame_err`=0, `overrun`=0.
- Glitch rejection: hold `rx` low for 100 cycles, then high. Expect the FSM to return to IDLE at the start sample, no `rx_valid`, no `frame_err`, and `busy` deasserted after ~217 cycles.
- Framing error: send 0xA5 with the stop bit driven 0, then return the line high. Expect one `frame_err` pulse, `rx_valid` to stay 0, and a following 0x5A frame to be received correctly.
- Overrun and handshake: hold `rx_ready`=0 and send 0x11 then 0x22. Expect `rx_valid`=1, `rx_data`=0x11, and `overrun`=1 after the second stop bit. Then raise `rx_ready` for one cycle: expect `rx_valid`=0 the next cycle and `overrun` still 1.
- Reset mid-frame: assert `rst_n`=0 during data bit 4 of 0xFF. Expect all outputs at reset values immediately. After release, a 0x3C frame is received correctly.
- Baud skew: send 0x55 and 0xAA at 425 and 443 cycles/bit, back-to-back with no idle gap. Expect both bytes received correctly with no errors.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receive-byte handshake between uart_rx (producer) and its consumer.
// The producer holds rx_data/rx_valid until the consumer takes the byte with rx_ready.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop synchronizer, falling-edge start detect, mid-bit sampling,
// and a single-entry valid/ready holding register with frame-error and overrun reporting.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge on the synchronized input
// START | counting to the middle of the start bit; a high sample there is a glitch
// DATA  | sampling 8 data bits, LSB first, one bit period apart
// STOP  | sampling the stop bit, then delivering, dropping or flagging the byte
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic        clk_50M,
  input  logic        rst_n,
  input  logic        rx_i,
  uart_rx_if.master   rx_if,
  output logic        frame_err_o,
  output logic        overrun_o,
  output logic        busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;

  logic            rx_meta_q, rx_s_q, rx_s_dly_q;
  logic            start_edge;
  logic            smp_start, smp_data, smp_stop;
  logic            accept, stop_good, stop_bad;

  // Synchronizer and edge-detect delay; reset high so a released reset never looks like a start edge
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_s_dly_q <= 1'b1;
    end else begin
      rx_meta_q  <= rx_i;
      rx_s_q     <= rx_meta_q;
      rx_s_dly_q <= rx_s_q;
    end
  end

  assign start_edge = rx_s_dly_q & ~rx_s_q;
  assign smp_start  = (state_q == S_START) && (cnt_q == CW'(HALF_BIT - 1));
  assign smp_data   = (state_q == S_DATA)  && (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign smp_stop   = (state_q == S_STOP)  && (cnt_q == CW'(CLKS_PER_BIT - 1));

  assign accept     = valid_q & rx_if.rx_ready;
  assign stop_good  = smp_stop & rx_s_q;
  assign stop_bad   = smp_stop & ~rx_s_q;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_edge) state_d = S_START;
      end
      S_START: begin
        if (smp_start) state_d = rx_s_q ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (smp_data && (bit_idx_q == 3'd7)) state_d = S_STOP;
      end
      S_STOP: begin
        if (smp_stop) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frame_err_d = stop_bad;

    if (state_q == S_IDLE) begin
      cnt_d     = '0;
      bit_idx_d = 3'd0;
    end else if (smp_start || smp_data || smp_stop) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    if (smp_data) begin
      shift_d   = {rx_s_q, shift_q[7:1]};
      bit_idx_d = 3'(bit_idx_q + 3'd1);
    end

    if (accept) valid_d = 1'b0;

    // A byte arriving on the same cycle as the accept replaces the old one; that is not an overrun
    if (stop_good) begin
      if (!valid_q || accept) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_if.rx_data  = data_q;
  assign rx_if.rx_valid = valid_q;
  assign frame_err_o    = frame_err_q;
  assign overrun_o      = overrun_q;
  assign busy_o         = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames driven bit by bit with hand-computed bytes,
// checking delivered data, delivery cycle, glitch/framing/overrun handling, reset and baud skew.
module tb_uart_rx;
  localparam int CPB     = 434;
  localparam int LATENCY = 4126;

  logic clk_50M = 1'b0;
  logic rst_n   = 1'b0;
  logic rx_i    = 1'b1;
  logic frame_err_o, overrun_o, busy_o;

  uart_rx_if u_if ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_50M     (clk_50M),
    .rst_n       (rst_n),
    .rx_i        (rx_i),
    .rx_if       (u_if),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  always #10 clk_50M = ~clk_50M;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always @(posedge clk_50M) cyc <= cyc + 1;

  logic [7:0] data_q[$];
  int         rise_q[$];
  int         fe_cnt = 0;
  int         fe_cyc = -1;
  logic       vld_prev = 1'b0;

  always @(negedge clk_50M) begin
    if (u_if.rx_valid && !vld_prev) begin
      data_q.push_back(u_if.rx_data);
      rise_q.push_back(cyc);
    end
    vld_prev = u_if.rx_valid;
    if (frame_err_o) begin
      fe_cnt = fe_cnt + 1;
      fe_cyc = cyc;
    end
  end

  task automatic clear_log();
    data_q.delete();
    rise_q.delete();
    fe_cnt = 0;
    fe_cyc = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_50M);
    #1;
  endtask

  // Called just after a clock edge; p is the cycle on which the start bit is driven
  task automatic send_frame(input logic [7:0] b, input int cpb, input logic stop, output int p);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    p  = cyc;
    for (int i = 0; i < 10; i++) begin
      rx_i = fr[i];
      repeat (cpb) @(posedge clk_50M);
      #1;
    end
  endtask

  task automatic test_reset();
    vectors++; if (u_if.rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_data got=%h exp=00", u_if.rx_data); end
    vectors++; if (u_if.rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", u_if.rx_valid); end
    vectors++; if (frame_err_o !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err got=%b exp=0", frame_err_o); end
    vectors++; if (overrun_o !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got=%b exp=0", overrun_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    rst_n = 1'b1;
    idle(5);
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL idle_busy got=%b exp=0", busy_o); end
  endtask

  task automatic test_single_frames();
    logic [7:0] v [4];
    int p;
    v = '{8'h47, 8'h42, 8'h49, 8'h31};
    u_if.rx_ready = 1'b1;
    foreach (v[i]) begin
      clear_log();
      send_frame(v[i], CPB, 1'b1, p);
      idle(20);
      vectors++; if (data_q.size() !== 1) begin miscompares++; $display("FAIL single_count byte=%h got=%0d exp=1", v[i], data_q.size()); end
      if (data_q.size() >= 1) begin
        vectors++; if (data_q[0] !== v[i]) begin miscompares++; $display("FAIL single_data got=%h exp=%h", data_q[0], v[i]); end
        vectors++; if (rise_q[0] !== p + LATENCY) begin miscompares++; $display("FAIL single_latency byte=%h got=%0d exp=%0d", v[i], rise_q[0] - p, LATENCY); end
      end
      vectors++; if (fe_cnt !== 0) begin miscompares++; $display("FAIL single_frame_err got=%0d exp=0", fe_cnt); end
      vectors++; if (overrun_o !== 1'b0) begin miscompares++; $display("FAIL single_overrun got=%b exp=0", overrun_o); end
      vectors++; if (u_if.rx_valid !== 1'b0) begin miscompares++; $display("FAIL single_valid_cleared got=%b exp=0", u_if.rx_valid); end
    end
  endtask

  task automatic test_glitch();
    int p;
    clear_log();
    rx_i = 1'b0;
    p = cyc;
    repeat (100) @(posedge clk_50M);
    #1;
    rx_i = 1'b1;
    while (cyc < p + 219) @(negedge clk_50M);
    vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL glitch_busy_at_sample got=%b exp=1", busy_o); end
    @(negedge clk_50M);
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL glitch_busy_after got=%b exp=0", busy_o); end
    @(posedge clk_50M);
    idle(50);
    vectors++; if (data_q.size() !== 0) begin miscompares++; $display("FAIL glitch_valid got=%0d exp=0", data_q.size()); end
    vectors++; if (fe_cnt !== 0) begin miscompares++; $display("FAIL glitch_frame_err got=%0d exp=0", fe_cnt); end
  endtask

  task automatic test_frame_error();
    int p;
    clear_log();
    send_frame(8'hA5, CPB, 1'b0, p);
    vectors++; if (fe_cnt !== 1) begin miscompares++; $display("FAIL ferr_count got=%0d exp=1", fe_cnt); end
    vectors++; if (fe_cyc !== p + LATENCY) begin miscompares++; $display("FAIL ferr_cycle got=%0d exp=%0d", fe_cyc - p, LATENCY); end
    vectors++; if (u_if.rx_valid !== 1'b0) begin miscompares++; $display("FAIL ferr_valid got=%b exp=0", u_if.rx_valid); end
    rx_i = 1'b1;
    idle(20);
    vectors++; if (fe_cnt !== 1) begin miscompares++; $display("FAIL ferr_single_pulse got=%0d exp=1", fe_cnt); end
    vectors++; if (data_q.size() !== 0) begin miscompares++; $display("FAIL ferr_dropped got=%0d exp=0", data_q.size()); end
    send_frame(8'h5A, CPB, 1'b1, p);
    idle(20);
    vectors++; if (data_q.size() !== 1) begin miscompares++; $display("FAIL ferr_next_count got=%0d exp=1", data_q.size()); end
    if (data_q.size() >= 1) begin
      vectors++; if (data_q[0] !== 8'h5A) begin miscompares++; $display("FAIL ferr_next_data got=%h exp=5a", data_q[0]); end
    end
  endtask

  task automatic test_overrun();
    int p;
    clear_log();
    u_if.rx_ready = 1'b0;
    send_frame(8'h11, CPB, 1'b1, p);
    idle(20);
    vectors++; if (overrun_o !== 1'b0) begin miscompares++; $display("FAIL ovr_first got=%b exp=0", overrun_o); end
    send_frame(8'h22, CPB, 1'b1, p);
    idle(20);
    vectors++; if (u_if.rx_valid !== 1'b1) begin miscompares++; $display("FAIL ovr_valid got=%b exp=1", u_if.rx_valid); end
    vectors++; if (u_if.rx_data !== 8'h11) begin miscompares++; $display("FAIL ovr_data got=%h exp=11", u_if.rx_data); end
    vectors++; if (overrun_o !== 1'b1) begin miscompares++; $display("FAIL ovr_flag got=%b exp=1", overrun_o); end
    u_if.rx_ready = 1'b1;
    @(posedge clk_50M);
    #1;
    u_if.rx_ready = 1'b0;
    vectors++; if (u_if.rx_valid !== 1'b0) begin miscompares++; $display("FAIL ovr_accept_valid got=%b exp=0", u_if.rx_valid); end
    vectors++; if (overrun_o !== 1'b1) begin miscompares++; $display("FAIL ovr_sticky got=%b exp=1", overrun_o); end
    idle(5);
    u_if.rx_ready = 1'b1;
  endtask

  task automatic test_mid_reset();
    int p;
    rx_i = 1'b0;
    repeat (CPB) @(posedge clk_50M);
    #1;
    rx_i = 1'b1;
    repeat (4 * CPB + 200) @(posedge clk_50M);
    #1;
    vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL rst_busy_before got=%b exp=1", busy_o); end
    rst_n = 1'b0;
    #2;
    vectors++; if (u_if.rx_data !== 8'h00) begin miscompares++; $display("FAIL rst_data got=%h exp=00", u_if.rx_data); end
    vectors++; if (u_if.rx_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got=%b exp=0", u_if.rx_valid); end
    vectors++; if (frame_err_o !== 1'b0) begin miscompares++; $display("FAIL rst_frame_err got=%b exp=0", frame_err_o); end
    vectors++; if (overrun_o !== 1'b0) begin miscompares++; $display("FAIL rst_overrun got=%b exp=0", overrun_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    idle(3);
    rst_n = 1'b1;
    idle(5);
    clear_log();
    send_frame(8'h3C, CPB, 1'b1, p);
    idle(20);
    vectors++; if (data_q.size() !== 1) begin miscompares++; $display("FAIL rst_next_count got=%0d exp=1", data_q.size()); end
    if (data_q.size() >= 1) begin
      vectors++; if (data_q[0] !== 8'h3C) begin miscompares++; $display("FAIL rst_next_data got=%h exp=3c", data_q[0]); end
      vectors++; if (rise_q[0] !== p + LATENCY) begin miscompares++; $display("FAIL rst_next_latency got=%0d exp=%0d", rise_q[0] - p, LATENCY); end
    end
    vectors++; if (fe_cnt !== 0) begin miscompares++; $display("FAIL rst_next_frame_err got=%0d exp=0", fe_cnt); end
  endtask

  task automatic test_baud_skew();
    int p1, p2;
    clear_log();
    send_frame(8'h55, 425, 1'b1, p1);
    send_frame(8'hAA, 443, 1'b1, p2);
    idle(20);
    vectors++; if (data_q.size() !== 2) begin miscompares++; $display("FAIL skew_count got=%0d exp=2", data_q.size()); end
    if (data_q.size() >= 2) begin
      vectors++; if (data_q[0] !== 8'h55) begin miscompares++; $display("FAIL skew_data0 got=%h exp=55", data_q[0]); end
      vectors++; if (data_q[1] !== 8'hAA) begin miscompares++; $display("FAIL skew_data1 got=%h exp=aa", data_q[1]); end
      vectors++; if (rise_q[1] !== p2 + LATENCY) begin miscompares++; $display("FAIL skew_latency1 got=%0d exp=%0d", rise_q[1] - p2, LATENCY); end
    end
    vectors++; if (fe_cnt !== 0) begin miscompares++; $display("FAIL skew_frame_err got=%0d exp=0", fe_cnt); end
    vectors++; if (overrun_o !== 1'b0) begin miscompares++; $display("FAIL skew_overrun got=%b exp=0", overrun_o); end
  endtask

  initial begin
    #3_000_000;
    miscompares++;
    $display("FAIL watchdog cycles=%0d limit reached", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "timeout");
  end

  initial begin
    u_if.rx_ready = 1'b1;
    rst_n = 1'b0;
    rx_i  = 1'b1;
    repeat (3) @(posedge clk_50M);
    #1;
    test_reset();
    test_single_frames();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_mid_reset();
    test_baud_skew();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
